// File: rtl/memctrl.sv
// memctrl: sole owner of the byte-wide unified RAM port.
// It arbitrates between icache word reads and LSB 1/2/4-byte loads and stores.
// Each access is broken into consecutive single-byte RAM cycles. The assembled
// result comes back with a one-cycle done pulse.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes every register
//   clear               pipeline flush; aborts an in-flight icache read
//   mem_din/mem_dout    RAM read byte / write byte
//   mem_a, mem_wr       RAM byte address, 1 = write
//   io_buffer_full      UART buffer full (only used with MEMCTRL_IO_STALL_EN)
//   icache_*            icache request/accept/done handshake and 32-bit word
//   lsb_*               LSB request/accept/done handshake, data and controls
//
// Optional build macro: MEMCTRL_IO_STALL_EN
//   When defined, a store byte whose address has [17:16] == 2'b11 is not
//   presented while io_buffer_full is high. mem_wr stays low and the byte
//   waits until the buffer drains.
module memctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  icache_to_memctrl,
  input  logic [ADDR_WIDTH-1:0] icache_addr,
  output logic                  icache_received,
  output logic                  memctrl_to_icache,
  output logic [31:0]           icache_inst,
  input  logic                  lsb_req,
  input  logic                  lsb_we,
  input  logic [1:0]            lsb_width,
  input  logic                  lsb_signed,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [31:0]           lsb_wdata,
  output logic                  lsb_received,
  output logic                  lsb_done,
  output logic [31:0]           lsb_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                state_q, state_n;
  logic [1:0]            cnt_q, cnt_n;
  logic [1:0]            len_m1_q, len_m1_n;   // access length minus one
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_n;         // address of the next byte
  logic                  is_ic_q, is_ic_n;     // current access belongs to icache
  logic                  sgn_q, sgn_n;
  logic                  last_lsb_q, last_lsb_n; // 1 = LSB was granted last
  logic                  io_wait_q, io_wait_n; // current write byte held back
  logic [3:0][7:0]       wdata_q, wdata_n;     // latched store data
  logic [3:0][7:0]       lanes_q, lanes_n;     // captured read bytes
  logic [3:0][7:0]       lanes_cap;

  logic [7:0]            mem_dout_n;
  logic [ADDR_WIDTH-1:0] mem_a_n, acc_addr;
  logic                  mem_wr_n;
  logic                  ic_recv_n, ic_done_n, lsb_recv_n, lsb_done_n;
  logic [31:0]           icache_inst_n, lsb_rdata_n;
  logic                  grant_ic, grant_lsb;

  // Store stall qualifiers. stall_acc covers the first byte at accept time,
  // stall_ptr the byte about to be presented, stall_cur the byte on the port.
  logic                  stall_acc, stall_ptr, stall_cur;
`ifdef MEMCTRL_IO_STALL_EN
  assign stall_acc = io_buffer_full && (lsb_addr[17:16] == 2'b11);
  assign stall_ptr = io_buffer_full && (ptr_q[17:16] == 2'b11);
  assign stall_cur = io_buffer_full && (mem_a[17:16] == 2'b11);
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign stall_acc = 1'b0;
  assign stall_ptr = 1'b0;
  assign stall_cur = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      len_m1_q          <= '0;
      ptr_q             <= '0;
      is_ic_q           <= 1'b0;
      sgn_q             <= 1'b0;
      last_lsb_q        <= 1'b1;
      io_wait_q         <= 1'b0;
      wdata_q           <= '0;
      lanes_q           <= '0;
      mem_dout          <= '0;
      mem_a             <= '0;
      mem_wr            <= 1'b0;
      icache_received   <= 1'b0;
      memctrl_to_icache <= 1'b0;
      icache_inst       <= '0;
      lsb_received      <= 1'b0;
      lsb_done          <= 1'b0;
      lsb_rdata         <= '0;
    end else if (rdy) begin
      state_q           <= state_n;
      cnt_q             <= cnt_n;
      len_m1_q          <= len_m1_n;
      ptr_q             <= ptr_n;
      is_ic_q           <= is_ic_n;
      sgn_q             <= sgn_n;
      last_lsb_q        <= last_lsb_n;
      io_wait_q         <= io_wait_n;
      wdata_q           <= wdata_n;
      lanes_q           <= lanes_n;
      mem_dout          <= mem_dout_n;
      mem_a             <= mem_a_n;
      mem_wr            <= mem_wr_n;
      icache_received   <= ic_recv_n;
      memctrl_to_icache <= ic_done_n;
      icache_inst       <= icache_inst_n;
      lsb_received      <= lsb_recv_n;
      lsb_done          <= lsb_done_n;
      lsb_rdata         <= lsb_rdata_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    cnt_n         = cnt_q;
    len_m1_n      = len_m1_q;
    ptr_n         = ptr_q;
    is_ic_n       = is_ic_q;
    sgn_n         = sgn_q;
    last_lsb_n    = last_lsb_q;
    io_wait_n     = io_wait_q;
    wdata_n       = wdata_q;
    lanes_n       = lanes_q;
    mem_dout_n    = mem_dout;
    mem_a_n       = mem_a;
    mem_wr_n      = mem_wr;
    ic_recv_n     = 1'b0;
    ic_done_n     = 1'b0;
    lsb_recv_n    = 1'b0;
    lsb_done_n    = 1'b0;
    icache_inst_n = icache_inst;
    lsb_rdata_n   = lsb_rdata;
    grant_ic      = 1'b0;
    grant_lsb     = 1'b0;
    acc_addr      = lsb_addr;
    lanes_cap          = lanes_q;
    lanes_cap[cnt_q]   = mem_din;

    case (state_q)
      IDLE: begin
        // Round robin on a tie. clear blocks only the icache side.
        grant_ic  = icache_to_memctrl && !clear && (!lsb_req || last_lsb_q);
        grant_lsb = lsb_req && !grant_ic;
        if (grant_ic || grant_lsb) begin
          acc_addr   = grant_ic ? icache_addr : lsb_addr;
          mem_a_n    = acc_addr;
          ptr_n      = acc_addr + ADDR_WIDTH'(1);
          cnt_n      = '0;
          is_ic_n    = grant_ic;
          last_lsb_n = grant_lsb;
          if (grant_ic) begin
            ic_recv_n = 1'b1;
            len_m1_n  = 2'd3;
            mem_wr_n  = 1'b0;
            state_n   = READ;
          end else begin
            lsb_recv_n = 1'b1;
            sgn_n      = lsb_signed;
            wdata_n    = lsb_wdata;
            case (lsb_width)
              2'd0:    len_m1_n = 2'd0;
              2'd1:    len_m1_n = 2'd1;
              default: len_m1_n = 2'd3;
            endcase
            if (lsb_we) begin
              mem_dout_n = lsb_wdata[7:0];
              mem_wr_n   = !stall_acc;
              io_wait_n  = stall_acc;
              state_n    = WRITE;
            end else begin
              mem_wr_n = 1'b0;
              state_n  = READ;
            end
          end
        end
      end

      READ: begin
        if (clear && is_ic_q) begin
          // A flushed fetch is dropped without a done pulse.
          mem_a_n = '0;
          state_n = IDLE;
        end else begin
          lanes_n = lanes_cap;
          cnt_n   = cnt_q + 2'd1;
          if (cnt_q != len_m1_q) begin
            mem_a_n = ptr_q;
            ptr_n   = ptr_q + ADDR_WIDTH'(1);
          end else begin
            mem_a_n = '0;
            state_n = IDLE;
            if (is_ic_q) begin
              ic_done_n     = 1'b1;
              icache_inst_n = lanes_cap;
            end else begin
              lsb_done_n = 1'b1;
              case (len_m1_q)
                2'd0:    lsb_rdata_n = {{24{sgn_q & lanes_cap[0][7]}}, lanes_cap[0]};
                2'd1:    lsb_rdata_n = {{16{sgn_q & lanes_cap[1][7]}}, lanes_cap[1], lanes_cap[0]};
                default: lsb_rdata_n = lanes_cap;
              endcase
            end
          end
        end
      end

      WRITE: begin
        if (io_wait_q) begin
          // Byte already on the bus; enable the write once the buffer drains.
          if (!stall_cur) begin
            mem_wr_n  = 1'b1;
            io_wait_n = 1'b0;
          end
        end else if (cnt_q != len_m1_q) begin
          mem_a_n    = ptr_q;
          ptr_n      = ptr_q + ADDR_WIDTH'(1);
          cnt_n      = cnt_q + 2'd1;
          mem_dout_n = wdata_q[cnt_q + 2'd1];
          mem_wr_n   = !stall_ptr;
          io_wait_n  = stall_ptr;
        end else begin
          mem_wr_n   = 1'b0;
          mem_a_n    = '0;
          lsb_done_n = 1'b1;
          state_n    = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
